serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/full_adder.sv | 31 +++
 rtl/half_adder.sv | 15 +
 rtl/serial_add_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state width and
// the binary-encoded FSM states.
package serial_add_ctrl_pkg;

  localparam int STATE_W = 2;

  // Encoding 2'd3 is unused; the FSM recovers from it to S_IDLE.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders and an OR of their carries.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s1),
    .c (c1)
  );

  half_adder u_ha1 (
    .a (s1),
    .b (ci),
    .s (s),
    .c (c2)
  );

  // At most one of the half-adder carries can be set, so OR merges them.
  always_comb co = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: the basic cell of the serial adder datapath.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum is the XOR of the inputs; carry is their AND.
  always_comb begin
    s = a ^ b;
    c = a & b;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit unsigned operands LSB
// first through one shared full-adder cell, one bit per clock.
//
// Handshake: start is sampled only in IDLE; the accepting edge captures A
// and B, after which they may change freely. busy is high for the WIDTH RUN
// cycles; done is a one-cycle pulse in the DONE state and is never high
// together with busy. sum/carry are valid from done until the next accepted
// start. start seen in RUN or DONE is dropped, not queued.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy,
  output logic             done,
  output state_e           dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State and datapath registers; reset clears everything, aborting any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath sequencing; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    c_d     = c_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          c_d     = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Result bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
        sum_d  = {fa_s, sum_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_co;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          carry_d = fa_co;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    sum       = sum_q;
    carry     = carry_q;
    dbg_state = state_q;
  end

endmodule
